// File: rtl/mem_burst_responder.sv
// Word-organised memory with a fixed-latency, fully pipelined read path and single-cycle writes.
// Optional MEM_ALIGN_CHECK_EN rejects odd byte addresses and reports them on addr_err.
module mem_burst_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic [3:0]            pending,
  output logic                  addr_err
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 1;
  localparam int unsigned DEPTH   = 1 << WORD_AW;

  logic [15:0]        mem [DEPTH];
  logic [WORD_AW-1:0] word_c;
  logic               misaligned_c;
  logic               rd_acc_c;
  logic               wr_acc_c;
  logic               wr_rej_c;
  logic [15:0]        rd_data_c;

  // Response pipeline: stage 0 holds the snapshot taken at the accepting edge.
  logic               valid_pipe [LATENCY];
  logic [15:0]        data_pipe  [LATENCY];
  logic               err_pipe   [LATENCY];

  assign word_c = addr[ADDR_WIDTH-1:1];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_c = addr[0];
`else
  logic unused_addr_lsb_c;
  assign misaligned_c      = 1'b0;
  assign unused_addr_lsb_c = addr[0];
`endif

  assign rd_acc_c  = enable & ~wr;
  assign wr_acc_c  = enable & wr & ~misaligned_c;
  assign wr_rej_c  = enable & wr & misaligned_c;
  assign rd_data_c = (rd_acc_c && !misaligned_c) ? mem[word_c] : 16'h0000;

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[word_c] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_pipe[i] <= 1'b0;
        data_pipe[i]  <= 16'h0000;
        err_pipe[i]   <= 1'b0;
      end
      pending <= 4'd0;
    end else begin
      valid_pipe[0] <= rd_acc_c;
      data_pipe[0]  <= rd_data_c;
      err_pipe[0]   <= rd_acc_c & misaligned_c;
      for (int i = 1; i < LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
        err_pipe[i]   <= err_pipe[i-1];
      end
      // A rejected write flags addr_err in the very next cycle, bypassing the read delay.
      if (wr_rej_c) begin
        err_pipe[LATENCY-1] <= 1'b1;
      end
      pending <= pending + 4'(rd_acc_c) - 4'(valid_pipe[LATENCY-1]);
    end
  end

  assign data_valid = valid_pipe[LATENCY-1];
  assign data_out   = data_pipe[LATENCY-1];
  assign addr_err   = err_pipe[LATENCY-1];

endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width; storage holds 2^(ADDR_WIDTH-1) 16-bit words.
REQ-002 SHALL have parameter LATENCY, default 4, read-request-to-data cycles; legal range 1..8.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  request strobe, one request per cycle when high.
REQ-006 SHALL have port wr  input  1  request type when enable=1: 1 = write, 0 = read.
REQ-007 SHALL have port addr  input  ADDR_WIDTH  byte address of request; addr[ADDR_WIDTH-1:1] selects word.
REQ-008 SHALL have port data_in  input  16  write data, sampled when enable=1 and wr=1.
REQ-009 SHALL have port data_out  output  16  read data, meaningful only while data_valid=1.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse per completed read.
REQ-011 SHALL have port pending  output  4  count of reads in flight.
REQ-012 SHALL have port addr_err  output  1  misalignment flag (see Configuration).

Function
REQ-013 Read (enable=1, wr=0) SHALL snapshot the addressed word at the accepting edge; data_valid=1 with that data exactly LATENCY cycles after that edge.
REQ-014 Reads SHALL be fully pipelined: a read every cycle accepted, no backpressure, responses in issue order.
REQ-015 Write (enable=1, wr=1) SHALL update the word at the accepting edge; no data_valid generated.
REQ-016 Read issued same cycle or later than a write to same word SHALL return new data; reads issued before it SHALL return old data (snapshot rule).
REQ-017 data_out SHALL be 16'h0000 whenever data_valid=0.
REQ-018 pending SHALL increment on read accept, decrement on data_valid cycle, unchanged when both occur same cycle; maximum value LATENCY, never wraps.
REQ-019 enable=0 cycles SHALL insert bubbles; pipeline continues advancing.
REQ-020 Highest address word (all-ones addr) SHALL be readable/writable; no wrap into other words.
REQ-021 wr and data_in SHALL be ignored when enable=0.

Reset
REQ-022 rst_n low SHALL immediately clear data_valid, data_out, pending, addr_err to 0.
REQ-023 Reads in flight at reset assertion SHALL be discarded; no data_valid after rst_n releases for them.
REQ-024 Storage contents SHALL NOT be altered by reset.
REQ-025 First request SHALL be accepted on first rising edge with rst_n high.

Configuration
REQ-026 Macro MEM_ALIGN_CHECK_EN defined: request with addr[0]=1 SHALL be rejected (writes not performed); rejected read still occupies a pipeline slot, returns data_valid=1, data_out=0, addr_err=1 in its response cycle.
REQ-027 Rejected write SHALL pulse addr_err=1 the cycle after acceptance, with no storage change.
REQ-028 Macro undefined: addr[0] ignored, addr_err tied 0.

Verification
REQ-029 Write 0x1234 to addr 0x0010, next cycle read 0x0010 -> data_valid high 4 cycles after read, data_out=0x1234, pending 1 during wait.
REQ-030 Back-to-back reads 0x0000,0x0002,0x0004,0x0006 (preloaded 0xA0..0xA3) -> four consecutive data_valid cycles, in order, pending peaks at 4.
REQ-031 Read 0x0020 (old 0x5555) then write 0xBEEF to 0x0020 next cycle -> read returns 0x5555; subsequent read returns 0xBEEF.
REQ-032 Two reads issued, rst_n pulsed low for 1 cycle two cycles later -> no data_valid ever, pending=0 immediately.
REQ-033 Read with bubbles (enable pattern 1,0,1) at LATENCY=1 build -> data_valid pattern 1,0,1 shifted one cycle.
REQ-034 With MEM_ALIGN_CHECK_EN: write 0x7777 to 0x0031, read 0x0031, read 0x0030 -> addr_err pulse after write; odd read returns 0 with addr_err=1; word 0x0030 unchanged.
